// File: rtl/instr_fetch_unit.sv
// Program store and fetch sequencer feeding the processor's din port.
// Words are loaded while idle, then replayed from address 0 in step with the one-hot tick.
module instr_fetch_unit #(
   parameter int         ADDR_W    = 5,
   parameter logic [2:0] MOVI_OP   = 3'b111,
   parameter logic [2:0] ADDI_OP   = 3'b010,
   parameter logic [8:0] HALT_WORD = 9'h000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        tick,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [8:0]        prog_data,
   output logic [8:0]        din,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic [15:0]       retired
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   localparam logic [3:0] T_0001 = 4'b0001;
   localparam logic [3:0] T_0010 = 4'b0010;
   localparam logic [3:0] T_0100 = 4'b0100;
   localparam logic [3:0] T_1000 = 4'b1000;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [2:0]        r_op_q;
   logic [15:0]       r_retired;
   logic [8:0]        r_mem [DEPTH];

   logic [ADDR_W-1:0] w_pc_plus1;
   logic [8:0]        w_cur_word;
   logic [8:0]        w_imm_word;
   logic              w_two_q;

   // Immediate address wraps naturally at the top of the store.
   assign w_pc_plus1 = r_pc + ADDR_W'(1);
   assign w_cur_word = r_mem[r_pc];
   assign w_imm_word = r_mem[w_pc_plus1];
   assign w_two_q    = (r_op_q == MOVI_OP) || (r_op_q == ADDI_OP);

   always_comb begin
      din = 9'h000;
      if (r_state == S_RUN) begin
         case (tick)
            T_0001:                 din = w_cur_word;
            T_0010, T_0100, T_1000: din = w_two_q ? w_imm_word : 9'h000;
            default:                din = 9'h000;
         endcase
      end
   end

   // Program store has no reset so a reset mid-run keeps the loaded program.
   always_ff @(posedge clk) begin
      if ((r_state == S_LOAD) && prog_we) begin
         r_mem[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_LOAD;
         r_pc      <= '0;
         r_op_q    <= 3'b000;
         r_retired <= 16'h0000;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (run && (tick == T_1000)) begin
                  r_state <= S_RUN;
                  r_pc    <= '0;
               end
            end
            S_RUN: begin
               if (tick == T_0001) begin
                  r_op_q <= w_cur_word[8:6];
                  if (w_cur_word == HALT_WORD) begin
                     r_state <= S_HALT;
                  end
               end else if (tick == T_1000) begin
                  // The in-flight instruction retires even when run has dropped.
                  if (r_retired != 16'hFFFF) begin
                     r_retired <= r_retired + 16'd1;
                  end
                  if (!run) begin
                     r_state <= S_LOAD;
                     r_pc    <= '0;
                  end else begin
                     r_pc <= w_two_q ? (r_pc + ADDR_W'(2)) : w_pc_plus1;
                  end
               end
            end
            S_HALT: begin
               if (!run && (tick == T_1000)) begin
                  r_state <= S_LOAD;
                  r_pc    <= '0;
               end
            end
            default: begin
               r_state <= S_LOAD;
               r_pc    <= '0;
            end
         endcase
      end
   end

   assign pc      = r_pc;
   assign busy    = (r_state == S_RUN);
   assign halted  = (r_state == S_HALT);
   assign retired = r_retired;

endmodule
